// File: rtl/cache_port_arbiter.sv
// Shares one line-memory port between the I-cache miss path and the D-cache miss/writeback path.
// Optional macro ARB_ROUND_ROBIN_EN swaps fixed data priority for alternating priority on contention.
module cache_port_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t state, next_state;
    logic   d_req, grant_d, grant_i;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_d;

    // On contention the data side wins only if the instruction side owned the previous grant.
    always_comb begin
        d_req   = d_read | d_write;
        grant_d = d_req && (!i_read || !last_owner_d);
        grant_i = i_read && !grant_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_d <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_d) begin
                last_owner_d <= 1'b1;
            end else if (grant_i) begin
                last_owner_d <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        d_req   = d_read | d_write;
        grant_d = d_req;
        grant_i = i_read && !grant_d;
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    next_state = SERVE_D;
                end else if (grant_i) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Address and write line are captured at grant so the requester may change them during service.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_write <= d_write;
                        mem_read  <= !d_write;
                    end else if (grant_i) begin
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                SERVE_I: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        i_resp    <= 1'b1;
                        i_rdata   <= mem_rdata;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        d_resp    <= 1'b1;
                        d_rdata   <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: expected responses are queued when requests are
// raised and popped when i_resp/d_resp fires.
module tb_cache_port_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, d_read, d_write, mem_resp;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_wdata, mem_rdata;
    logic              i_resp, d_resp, mem_read, mem_write;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    typedef struct {
        logic              side;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cache_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        mem_resp  = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
    endtask

    task automatic push_exp(input logic side, input logic [LINE_W-1:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) begin
            e = sb.pop_front();
        end else begin
            e.side = 1'b0;
            e.data = '0;
        end
    endtask

    task automatic wait_strobe(output int cyc);
        cyc = 0;
        while (!(mem_read || mem_write) && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic quick_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        n_checks++;
        if ({mem_read, mem_write, i_resp, d_resp, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0)
            $display("[TB] FAIL reset_outputs: got rd=%b wr=%b ir=%b dr=%b addr=%h required all 0",
                     mem_read, mem_write, i_resp, d_resp, mem_addr);
        else n_pass++;
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_i_read();
        exp_t e;
        bit   ok;
        i_read = 1'b1;
        i_addr = 32'h0000_1040;
        push_exp(1'b0, {32{8'hA5}});
        step();
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b1, 1'b0, 32'h0000_1040, 256'h0})
            $display("[TB] FAIL i_grant: got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=00001040",
                     mem_read, mem_write, mem_addr);
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if (mem_read !== 1'b1 || i_resp !== 1'b0)
            $display("[TB] FAIL i_hold: got rd=%b i_resp=%b required rd=1 i_resp=0", mem_read, i_resp);
        else n_pass++;
        mem_resp  = 1'b1;
        mem_rdata = sb[0].data;
        step();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        pop_exp(e, ok);
        n_checks++;
        if (!ok || i_resp !== 1'b1 || d_resp !== 1'b0 || mem_read !== 1'b0 || e.side !== 1'b0
            || i_rdata !== e.data)
            $display("[TB] FAIL i_resp: got ir=%b dr=%b rd=%b rdata=%h required ir=1 dr=0 rd=0 rdata=%h",
                     i_resp, d_resp, mem_read, i_rdata, e.data);
        else n_pass++;
        i_read = 1'b0;
        step();
        n_checks++;
        if (i_resp !== 1'b0 || i_rdata !== {32{8'hA5}})
            $display("[TB] FAIL i_resp_once: got ir=%b rdata=%h required ir=0 rdata held", i_resp, i_rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_d_writeback();
        exp_t              e;
        bit                ok;
        logic [LINE_W-1:0] wpat = {8{32'h1234_5678}};
        d_write = 1'b1;
        d_addr  = 32'h8000_0020;
        d_wdata = wpat;
        push_exp(1'b1, {8{32'hDEAD_BEEF}});
        step();
        n_checks++;
        if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h8000_0020, wpat})
            $display("[TB] FAIL d_grant: got rd=%b wr=%b addr=%h required rd=0 wr=1 addr=80000020",
                     mem_read, mem_write, mem_addr);
        else n_pass++;
        d_addr  = 32'h1111_0000;
        d_wdata = ~wpat;
        step();
        step();
        n_checks++;
        if ({mem_write, mem_addr, mem_wdata} !== {1'b1, 32'h8000_0020, wpat})
            $display("[TB] FAIL d_latched: got wr=%b addr=%h required wr=1 addr=80000020", mem_write, mem_addr);
        else n_pass++;
        mem_resp  = 1'b1;
        mem_rdata = sb[0].data;
        step();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        pop_exp(e, ok);
        n_checks++;
        if (!ok || d_resp !== 1'b1 || i_resp !== 1'b0 || mem_write !== 1'b0 || e.side !== 1'b1
            || d_rdata !== e.data)
            $display("[TB] FAIL d_resp: got dr=%b ir=%b wr=%b rdata=%h required dr=1 ir=0 wr=0 rdata=%h",
                     d_resp, i_resp, mem_write, d_rdata, e.data);
        else n_pass++;
        d_write = 1'b0;
        step();
        n_checks++;
        if (d_resp !== 1'b0)
            $display("[TB] FAIL d_resp_once: got dr=%b required 0", d_resp);
        else n_pass++;
        step();
    endtask

    task automatic test_contention();
        exp_t e;
        bit   ok;
        quick_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_2000;
        d_read = 1'b1;
        d_addr = 32'h0000_3000;
        push_exp(1'b1, {8{32'h0D0D_0001}});
        push_exp(1'b0, {8{32'h1111_0002}});
        step();
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_3000)
            $display("[TB] FAIL contend_d_first: got rd=%b addr=%h required rd=1 addr=00003000", mem_read, mem_addr);
        else n_pass++;
        step();
        mem_resp  = 1'b1;
        mem_rdata = sb[0].data;
        step();
        mem_resp = 1'b0;
        pop_exp(e, ok);
        n_checks++;
        if (!ok || d_resp !== 1'b1 || i_resp !== 1'b0 || e.side !== 1'b1 || d_rdata !== e.data)
            $display("[TB] FAIL contend_d_resp: got dr=%b ir=%b rdata=%h required dr=1 ir=0 rdata=%h",
                     d_resp, i_resp, d_rdata, e.data);
        else n_pass++;
        d_read = 1'b0;
        step();
        n_checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0)
            $display("[TB] FAIL contend_gap: got rd=%b wr=%b required 0 0 at k+2", mem_read, mem_write);
        else n_pass++;
        step();
        n_checks++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h0000_2000)
            $display("[TB] FAIL contend_i_next: got rd=%b addr=%h required rd=1 addr=00002000 at k+3",
                     mem_read, mem_addr);
        else n_pass++;
        mem_resp  = 1'b1;
        mem_rdata = sb[0].data;
        step();
        mem_resp = 1'b0;
        pop_exp(e, ok);
        n_checks++;
        if (!ok || i_resp !== 1'b1 || d_resp !== 1'b0 || e.side !== 1'b0 || i_rdata !== e.data)
            $display("[TB] FAIL contend_i_resp: got ir=%b dr=%b rdata=%h required ir=1 dr=0 rdata=%h",
                     i_resp, d_resp, i_rdata, e.data);
        else n_pass++;
        i_read = 1'b0;
        step();
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        int   cyc;
        bit   order [3];
`ifdef ARB_ROUND_ROBIN_EN
        order = '{1'b1, 1'b0, 1'b1};
`else
        order = '{1'b1, 1'b1, 1'b1};
`endif
        quick_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_4000;
        d_read = 1'b1;
        d_addr = 32'h0000_5000;
        for (int n = 0; n < 3; n++) begin
            push_exp(order[n], {8{32'hC0DE_0000 + 32'(n)}});
        end
        for (int n = 0; n < 3; n++) begin
            wait_strobe(cyc);
            n_checks++;
            if (cyc >= 20 || mem_addr !== (order[n] ? 32'h0000_5000 : 32'h0000_4000))
                $display("[TB] FAIL b2b_grant%0d: got addr=%h wait=%0d required addr=%h",
                         n, mem_addr, cyc, order[n] ? 32'h0000_5000 : 32'h0000_4000);
            else n_pass++;
            mem_resp  = 1'b1;
            mem_rdata = sb[0].data;
            step();
            mem_resp = 1'b0;
            pop_exp(e, ok);
            n_checks++;
            if (!ok || (i_resp ^ d_resp) !== 1'b1 || d_resp !== e.side
                || (d_resp ? d_rdata : i_rdata) !== e.data)
                $display("[TB] FAIL b2b_resp%0d: got ir=%b dr=%b required side=%b data=%h",
                         n, i_resp, d_resp, e.side, e.data);
            else n_pass++;
            if (n == 2) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
            step();
        end
        step();
    endtask

    task automatic test_spurious();
        exp_t e;
        bit   ok;
        bit   bad = 1'b0;
        mem_resp  = 1'b1;
        mem_rdata = {32{8'h3C}};
        step();
        mem_resp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (i_resp || d_resp || mem_read || mem_write) bad = 1'b1;
            step();
        end
        n_checks++;
        if (bad !== 1'b0)
            $display("[TB] FAIL spurious_resp: got activity=%b required 0", bad);
        else n_pass++;
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_6000;
        push_exp(1'b1, {8{32'h600D_600D}});
        step();
        n_checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0)
            $display("[TB] FAIL rw_both: got rd=%b wr=%b required rd=0 wr=1", mem_read, mem_write);
        else n_pass++;
        mem_resp  = 1'b1;
        mem_rdata = sb[0].data;
        step();
        mem_resp = 1'b0;
        pop_exp(e, ok);
        n_checks++;
        if (!ok || d_resp !== 1'b1 || d_rdata !== e.data)
            $display("[TB] FAIL rw_both_resp: got dr=%b rdata=%h required dr=1 rdata=%h", d_resp, d_rdata, e.data);
        else n_pass++;
        d_read  = 1'b0;
        d_write = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        d_write = 1'b1;
        d_addr  = 32'h0000_7000;
        d_wdata = {8{32'hFACE_CAFE}};
        step();
        n_checks++;
        if (mem_write !== 1'b1)
            $display("[TB] FAIL midrst_grant: got wr=%b required 1", mem_write);
        else n_pass++;
        step();
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_read, mem_write, i_resp, d_resp, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0)
            $display("[TB] FAIL midrst_outputs: got wr=%b addr=%h required all 0", mem_write, mem_addr);
        else n_pass++;
        d_write = 1'b0;
        step();
        rst      = 1'b1;
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (d_resp || i_resp || mem_write || mem_read) bad = 1'b1;
            step();
        end
        n_checks++;
        if (bad !== 1'b0)
            $display("[TB] FAIL midrst_no_resp: got activity=%b required 0", bad);
        else n_pass++;
        n_checks++;
        if (sb.size() !== 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_i_read();
        test_d_writeback();
        test_contention();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion required finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
